// File: rtl/pipe_hazard_unit.sv
`default_nettype none
// =============================================================================
// Module : pipe_hazard_unit
// Forwarding selects, load-use / MDU stalls, mispredict flushes and saturating
// stall/flush event counters for a five-stage pipeline.
// Rev    : 1.0
// =============================================================================
module pipe_hazard_unit #(
    parameter int AW      = 5,
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    rs_d,
    input  logic [AW-1:0]    rt_d,
    input  logic [AW-1:0]    rs_e,
    input  logic [AW-1:0]    rt_e,
    input  logic [AW-1:0]    wa_e,
    input  logic [AW-1:0]    wa_m,
    input  logic [AW-1:0]    wa_w,
    input  logic             regwrite_e,
    input  logic             regwrite_m,
    input  logic             regwrite_w,
    input  logic             memtoreg_e,
    input  logic             memtoreg_m,
    input  logic             branch_e,
    input  logic             jump_e,
    input  logic             jumpr_e,
    input  logic             pcsrc_e,
    input  logic             predict_e,
    input  logic             mdu_start_e,
    input  logic             mdu_use_d,
    input  logic             clr_cnt,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic             flush_e,
    output logic [1:0]       fwd_a_e,
    output logic [1:0]       fwd_b_e,
    output logic [1:0]       fwd_s_d,
    output logic [1:0]       fwd_t_d,
    output logic             mdu_busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [0:0]       C_IDLE    = 1'b0;
    localparam logic [0:0]       C_BUSY    = 1'b1;
    localparam logic [7:0]       C_LAT_M1  = 8'(MDU_LAT - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [0:0]       state_q, state_d;
    logic [7:0]       mcnt_q, mcnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             w_load_use;
    logic             w_mdu_stall;
    logic             w_mispredict;
    logic             w_hold;

    // Register 0 is hard-wired, so a write to it is never a real producer.
    function automatic logic hit(input logic we, input logic [AW-1:0] wa,
                                 input logic [AW-1:0] ra);
        return we && (wa != '0) && (wa == ra);
    endfunction

    always_comb begin
        fwd_a_e = 2'b00;
        fwd_b_e = 2'b00;
        fwd_s_d = 2'b00;
        fwd_t_d = 2'b00;
        if (rst_n) begin
            if (hit(regwrite_m, wa_m, rs_e))      fwd_a_e = memtoreg_m ? 2'b11 : 2'b10;
            else if (hit(regwrite_w, wa_w, rs_e)) fwd_a_e = 2'b01;
            if (hit(regwrite_m, wa_m, rt_e))      fwd_b_e = memtoreg_m ? 2'b11 : 2'b10;
            else if (hit(regwrite_w, wa_w, rt_e)) fwd_b_e = 2'b01;

            // Loads in E/M have no data yet for D, so they are skipped as sources.
            if (hit(regwrite_e & ~memtoreg_e, wa_e, rs_d))      fwd_s_d = 2'b01;
            else if (hit(regwrite_m & ~memtoreg_m, wa_m, rs_d)) fwd_s_d = 2'b10;
            else if (hit(regwrite_w, wa_w, rs_d))               fwd_s_d = 2'b11;
            if (hit(regwrite_e & ~memtoreg_e, wa_e, rt_d))      fwd_t_d = 2'b01;
            else if (hit(regwrite_m & ~memtoreg_m, wa_m, rt_d)) fwd_t_d = 2'b10;
            else if (hit(regwrite_w, wa_w, rt_d))               fwd_t_d = 2'b11;
        end
    end

    assign w_load_use   = hit(regwrite_e & memtoreg_e, wa_e, rs_d)
                        | hit(regwrite_e & memtoreg_e, wa_e, rt_d);
    assign w_mdu_stall  = mdu_use_d & (mdu_busy | mdu_start_e);
    assign w_mispredict = (branch_e | jump_e | jumpr_e) & (pcsrc_e ^ predict_e);
    assign w_hold       = w_load_use | w_mdu_stall;

    // A redirect wins over any stall: the stalled D instruction is being flushed.
    always_comb begin
        stall_f = rst_n & w_hold & ~w_mispredict;
        stall_d = rst_n & w_hold & ~w_mispredict;
        flush_d = rst_n & w_mispredict;
        flush_e = rst_n & (w_hold | w_mispredict);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= C_IDLE;
            mcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            mcnt_q  <= mcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mcnt_d  = mcnt_q;
        if (mdu_start_e) begin
            state_d = C_BUSY;
            mcnt_d  = C_LAT_M1;
        end else if (state_q == C_BUSY) begin
            if (mcnt_q == 8'd0) state_d = C_IDLE;
            else                mcnt_d  = mcnt_q - 8'd1;
        end
    end

    always_comb begin
        mdu_busy = (state_q == C_BUSY);
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (clr_cnt) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall_d && (stall_cnt_q != '1))      stall_cnt_d = stall_cnt_q + C_CNT_ONE;
            if (w_mispredict && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + C_CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_unit.sv
`default_nettype none
// =============================================================================
// Module : tb_pipe_hazard_unit
// Directed scenarios plus randomized traffic checked every cycle against a
// behavioural model of pipe_hazard_unit.
// Rev    : 1.0
// =============================================================================
module tb_pipe_hazard_unit;

    localparam int AW      = 5;
    localparam int MDU_LAT = 4;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [AW-1:0]    rs_d, rt_d, rs_e, rt_e, wa_e, wa_m, wa_w;
    logic             regwrite_e, regwrite_m, regwrite_w, memtoreg_e, memtoreg_m;
    logic             branch_e, jump_e, jumpr_e, pcsrc_e, predict_e;
    logic             mdu_start_e, mdu_use_d, clr_cnt;
    logic             stall_f, stall_d, flush_d, flush_e, mdu_busy;
    logic [1:0]       fwd_a_e, fwd_b_e, fwd_s_d, fwd_t_d;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic chk_en  = 1'b0;
    int   m_rem   = 0;
    int   m_sc    = 0;
    int   m_fc    = 0;

    always #5 clk = ~clk;

    pipe_hazard_unit #(.AW(AW), .MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
        .wa_e(wa_e), .wa_m(wa_m), .wa_w(wa_w),
        .regwrite_e(regwrite_e), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
        .memtoreg_e(memtoreg_e), .memtoreg_m(memtoreg_m),
        .branch_e(branch_e), .jump_e(jump_e), .jumpr_e(jumpr_e),
        .pcsrc_e(pcsrc_e), .predict_e(predict_e),
        .mdu_start_e(mdu_start_e), .mdu_use_d(mdu_use_d), .clr_cnt(clr_cnt),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .fwd_s_d(fwd_s_d), .fwd_t_d(fwd_t_d),
        .mdu_busy(mdu_busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    function automatic bit hit(input logic we, input logic [AW-1:0] wa, input logic [AW-1:0] ra);
        return (we == 1'b1) && (wa != '0) && (wa == ra);
    endfunction

    function automatic int exp_fwd_e(input logic [AW-1:0] ra);
        if (!rst_n) return 0;
        if (hit(regwrite_m, wa_m, ra)) return memtoreg_m ? 3 : 2;
        if (hit(regwrite_w, wa_w, ra)) return 1;
        return 0;
    endfunction

    function automatic int exp_fwd_d(input logic [AW-1:0] ra);
        if (!rst_n) return 0;
        if (!memtoreg_e && hit(regwrite_e, wa_e, ra)) return 1;
        if (!memtoreg_m && hit(regwrite_m, wa_m, ra)) return 2;
        if (hit(regwrite_w, wa_w, ra)) return 3;
        return 0;
    endfunction

    function automatic bit exp_misp();
        return (branch_e || jump_e || jumpr_e) && (pcsrc_e != predict_e);
    endfunction

    function automatic bit exp_hold();
        bit lu;
        lu = memtoreg_e && (hit(regwrite_e, wa_e, rs_d) || hit(regwrite_e, wa_e, rt_d));
        return lu || (mdu_use_d && ((m_rem > 0) || mdu_start_e));
    endfunction

    function automatic bit exp_stall();
        return rst_n && exp_hold() && !exp_misp();
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_rem <= 0;
            m_sc  <= 0;
            m_fc  <= 0;
        end else begin
            if (clr_cnt) begin
                m_sc <= 0;
                m_fc <= 0;
            end else begin
                if (exp_stall() && m_sc < CNT_MAX) m_sc <= m_sc + 1;
                if (exp_misp() && m_fc < CNT_MAX)  m_fc <= m_fc + 1;
            end
            if (mdu_start_e)    m_rem <= MDU_LAT;
            else if (m_rem > 0) m_rem <= m_rem - 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model fwd_a_e", int'(fwd_a_e), exp_fwd_e(rs_e));
            chk("model fwd_b_e", int'(fwd_b_e), exp_fwd_e(rt_e));
            chk("model fwd_s_d", int'(fwd_s_d), exp_fwd_d(rs_d));
            chk("model fwd_t_d", int'(fwd_t_d), exp_fwd_d(rt_d));
            chk("model stall_f", int'(stall_f), int'(exp_stall()));
            chk("model stall_d", int'(stall_d), int'(exp_stall()));
            chk("model flush_d", int'(flush_d), int'(rst_n && exp_misp()));
            chk("model flush_e", int'(flush_e), int'(rst_n && (exp_hold() || exp_misp())));
            chk("model mdu_busy", int'(mdu_busy), int'(m_rem > 0));
            chk("model stall_cnt", int'(stall_cnt), m_sc);
            chk("model flush_cnt", int'(flush_cnt), m_fc);
        end
    end

    task automatic idle();
        rs_d = '0; rt_d = '0; rs_e = '0; rt_e = '0; wa_e = '0; wa_m = '0; wa_w = '0;
        regwrite_e = 0; regwrite_m = 0; regwrite_w = 0; memtoreg_e = 0; memtoreg_m = 0;
        branch_e = 0; jump_e = 0; jumpr_e = 0; pcsrc_e = 0; predict_e = 0;
        mdu_start_e = 0; mdu_use_d = 0; clr_cnt = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic load_use();
        memtoreg_e = 1; regwrite_e = 1; wa_e = 5; rt_d = 5;
    endtask

    initial begin
        rst_n = 0;
        idle();
        next_cycle();
        chk_en = 1'b1;
        // Hazards presented during reset must be masked.
        load_use();
        rs_e = 3; wa_m = 3; regwrite_m = 1; branch_e = 1; pcsrc_e = 1;
        @(negedge clk);
        chk("reset stall_d", int'(stall_d), 0);
        chk("reset flush_e", int'(flush_e), 0);
        chk("reset flush_d", int'(flush_d), 0);
        chk("reset fwd_a_e", int'(fwd_a_e), 0);
        chk("reset mdu_busy", int'(mdu_busy), 0);
        chk("reset stall_cnt", int'(stall_cnt), 0);

        next_cycle(); rst_n = 1; idle();
        wa_m = 3; wa_w = 3; rs_e = 3; rt_e = 3; regwrite_m = 1; regwrite_w = 1;
        @(negedge clk);
        chk("M alu fwd_a_e", int'(fwd_a_e), 2);
        chk("M alu fwd_b_e", int'(fwd_b_e), 2);
        next_cycle(); memtoreg_m = 1;
        @(negedge clk);
        chk("M load fwd_a_e", int'(fwd_a_e), 3);
        next_cycle(); regwrite_m = 0;
        @(negedge clk);
        chk("W fwd_a_e", int'(fwd_a_e), 1);

        next_cycle(); idle();
        regwrite_e = 1; regwrite_m = 1; regwrite_w = 1; memtoreg_e = 1;
        @(negedge clk);
        chk("r0 fwd_a_e", int'(fwd_a_e), 0);
        chk("r0 fwd_b_e", int'(fwd_b_e), 0);
        chk("r0 fwd_s_d", int'(fwd_s_d), 0);
        chk("r0 fwd_t_d", int'(fwd_t_d), 0);
        chk("r0 stall_d", int'(stall_d), 0);

        next_cycle(); idle(); clr_cnt = 1;
        next_cycle(); idle(); load_use();
        @(negedge clk);
        chk("lu stall_f", int'(stall_f), 1);
        chk("lu stall_d", int'(stall_d), 1);
        chk("lu flush_e", int'(flush_e), 1);
        chk("lu flush_d", int'(flush_d), 0);
        next_cycle(); idle();
        @(negedge clk);
        chk("lu after stall_d", int'(stall_d), 0);
        chk("lu stall_cnt", int'(stall_cnt), 1);

        next_cycle(); idle(); clr_cnt = 1;
        next_cycle(); idle(); mdu_start_e = 1; mdu_use_d = 1;
        @(negedge clk);
        chk("mdu N busy", int'(mdu_busy), 0);
        chk("mdu N stall_d", int'(stall_d), 1);
        for (int i = 1; i <= 4; i++) begin
            next_cycle(); idle(); mdu_use_d = 1;
            @(negedge clk);
            chk("mdu busy", int'(mdu_busy), 1);
            chk("mdu stall_d", int'(stall_d), 1);
        end
        next_cycle(); idle(); mdu_use_d = 1;
        @(negedge clk);
        chk("mdu done busy", int'(mdu_busy), 0);
        chk("mdu done stall_d", int'(stall_d), 0);
        chk("mdu stall_cnt", int'(stall_cnt), 5);

        next_cycle(); idle(); clr_cnt = 1;
        next_cycle(); idle(); load_use(); branch_e = 1; pcsrc_e = 1; predict_e = 0;
        @(negedge clk);
        chk("misp flush_d", int'(flush_d), 1);
        chk("misp flush_e", int'(flush_e), 1);
        chk("misp stall_f", int'(stall_f), 0);
        chk("misp stall_d", int'(stall_d), 0);
        next_cycle(); idle();
        @(negedge clk);
        chk("misp flush_cnt", int'(flush_cnt), 1);
        chk("misp stall_cnt", int'(stall_cnt), 0);

        next_cycle(); idle(); clr_cnt = 1;
        repeat (CNT_MAX) begin
            next_cycle(); idle(); load_use();
        end
        next_cycle(); idle(); load_use();
        @(negedge clk);
        chk("sat preload stall_cnt", int'(stall_cnt), 255);
        chk("sat stall_d", int'(stall_d), 1);
        next_cycle(); idle(); mdu_start_e = 1; branch_e = 1; pcsrc_e = 1;
        @(negedge clk);
        chk("sat hold stall_cnt", int'(stall_cnt), 255);
        next_cycle(); idle(); branch_e = 1; pcsrc_e = 1;
        @(negedge clk);
        chk("mid-op busy", int'(mdu_busy), 1);
        next_cycle(); idle(); rst_n = 0;
        @(negedge clk);
        chk("pre-reset busy", int'(mdu_busy), 1);
        chk("pre-reset flush_cnt", int'(flush_cnt), 2);
        next_cycle(); idle(); rst_n = 1;
        @(negedge clk);
        chk("abort busy", int'(mdu_busy), 0);
        chk("abort stall_cnt", int'(stall_cnt), 0);
        chk("abort flush_cnt", int'(flush_cnt), 0);

        repeat (3000) begin
            next_cycle();
            rs_d = AW'($urandom_range(0, 3)); rt_d = AW'($urandom_range(0, 3));
            rs_e = AW'($urandom_range(0, 3)); rt_e = AW'($urandom_range(0, 3));
            wa_e = AW'($urandom_range(0, 3)); wa_m = AW'($urandom_range(0, 3));
            wa_w = AW'($urandom_range(0, 3));
            regwrite_e = 1'($urandom_range(0, 1)); regwrite_m = 1'($urandom_range(0, 1));
            regwrite_w = 1'($urandom_range(0, 1)); memtoreg_e = 1'($urandom_range(0, 1));
            memtoreg_m = 1'($urandom_range(0, 1));
            branch_e = ($urandom_range(0, 3) == 0); jump_e = ($urandom_range(0, 7) == 0);
            jumpr_e = ($urandom_range(0, 7) == 0);
            pcsrc_e = 1'($urandom_range(0, 1)); predict_e = 1'($urandom_range(0, 1));
            mdu_start_e = ($urandom_range(0, 9) == 0);
            mdu_use_d = 1'($urandom_range(0, 1));
            clr_cnt = ($urandom_range(0, 49) == 0);
            rst_n = ($urandom_range(0, 149) != 0);
        end
        next_cycle(); idle(); rst_n = 1;
        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
